mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 30 +++
 rtl/mult_div_core.sv | 72 +++++++
 rtl/mult_div_unit.sv | 86 ++++++++
 tb/tb_mult_div_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_div_unit_pkg                                                    |
// | Op encodings and latency defaults shared with the control decoder.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  localparam int MULT_LAT_DEFAULT = 5;
  localparam int DIV_LAT_DEFAULT  = 10;

  // True for the multi-cycle ops that occupy the unit.
  function automatic logic md_is_long_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_div_core                                                        |
// | Combinational 32x32 multiply / divide producing next HI and LO.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mult_div_core
  import mult_div_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_next,
  output logic [31:0] lo_next,
  output logic        div_by_zero
);

  logic signed [63:0] w_sa;
  logic signed [63:0] w_sb;
  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic signed [31:0] w_as;
  logic signed [31:0] w_bs_safe;
  logic signed [31:0] w_quo_s;
  logic signed [31:0] w_rem_s;
  logic        [31:0] w_bu_safe;
  logic        [31:0] w_quo_u;
  logic        [31:0] w_rem_u;
  logic               w_b_zero;
  logic               w_s_ovf;

  assign w_sa     = {{32{a[31]}}, a};
  assign w_sb     = {{32{b[31]}}, b};
  assign w_prod_s = w_sa * w_sb;
  assign w_prod_u = {32'd0, a} * {32'd0, b};

  assign w_b_zero = (b == 32'd0);
  // MIN/-1 is steered to MIN/1: same quotient, zero remainder, no overflow.
  assign w_s_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  assign w_as      = a;
  assign w_bs_safe = (w_b_zero || w_s_ovf) ? 32'sd1 : b;
  assign w_quo_s   = w_as / w_bs_safe;
  assign w_rem_s   = w_as % w_bs_safe;

  assign w_bu_safe = w_b_zero ? 32'd1 : b;
  assign w_quo_u   = a / w_bu_safe;
  assign w_rem_u   = a % w_bu_safe;

  always_comb begin
    hi_next     = 32'd0;
    lo_next     = 32'd0;
    div_by_zero = 1'b0;
    case (op)
      MD_MULT:  {hi_next, lo_next} = w_prod_s;
      MD_MULTU: {hi_next, lo_next} = w_prod_u;
      MD_DIV: begin
        hi_next     = w_rem_s;
        lo_next     = w_quo_s;
        div_by_zero = w_b_zero;
      end
      MD_DIVU: begin
        hi_next     = w_rem_u;
        lo_next     = w_quo_u;
        div_by_zero = w_b_zero;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_div_unit                                                        |
// | HI/LO register file with fixed-latency multiply / divide sequencing. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEFAULT,
  parameter int DIV_LAT  = DIV_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MULTDIVControl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] result
);

  localparam int c_max_lat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int c_cnt_w   = $clog2(c_max_lat + 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic [3:0]         r_op;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  logic [31:0]        w_hi_next;
  logic [31:0]        w_lo_next;
  logic               w_div_by_zero;
  logic               w_is_mult;
  logic [c_cnt_w-1:0] w_lat;

  // Arithmetic runs from the latched copies so operand buses may change while busy.
  mult_div_core u_core (
    .op          (r_op),
    .a           (r_a),
    .b           (r_b),
    .hi_next     (w_hi_next),
    .lo_next     (w_lo_next),
    .div_by_zero (w_div_by_zero)
  );

  assign w_is_mult = (MULTDIVControl == MD_MULT) || (MULTDIVControl == MD_MULTU);
  assign w_lat     = w_is_mult ? c_cnt_w'(MULT_LAT) : c_cnt_w'(DIV_LAT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_op  <= 4'd0;
      r_a   <= 32'd0;
      r_b   <= 32'd0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - c_cnt_w'(1);
      if ((r_cnt == c_cnt_w'(1)) && !w_div_by_zero) begin
        r_hi <= w_hi_next;
        r_lo <= w_lo_next;
      end
    end else if (start && md_is_long_op(MULTDIVControl)) begin
      r_cnt <= w_lat;
      r_op  <= MULTDIVControl;
      r_a   <= A;
      r_b   <= B;
    end else if (MULTDIVControl == MD_MTHI) begin
      r_hi <= A;
    end else if (MULTDIVControl == MD_MTLO) begin
      r_lo <= A;
    end
  end

  assign busy   = (r_cnt != '0);
  assign HI     = r_hi;
  assign LO     = r_lo;
  assign result = (MULTDIVControl == MD_MFHI) ? r_hi : r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mult_div_unit                                                     |
// | Scoreboard bench: arithmetic reference model, queued expectations.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int ML = 5;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ctl;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] result;

  always #5 clk = ~clk;

  mult_div_unit #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .MULTDIVControl (ctl),
    .A              (a),
    .B              (b),
    .busy           (busy),
    .HI             (hi),
    .LO             (lo),
    .result         (result)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        op_q[$];
  logic [31:0] rd_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;
  logic [31:0] p_hi;
  logic [31:0] p_lo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: architectural HI/LO after op given the current HI/LO.
  function automatic void model_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                   inout logic [31:0] h, inout logic [31:0] l);
    longint          sx = longint'($signed(x));
    longint          sy = longint'($signed(y));
    longint unsigned ux = {32'd0, x};
    longint unsigned uy = {32'd0, y};
    logic [63:0]     p;
    logic [63:0]     q;
    logic [63:0]     r;
    case (op)
      MD_MULT:  begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
      MD_MULTU: begin p = ux * uy; h = p[63:32]; l = p[31:0]; end
      MD_DIV:   if (y != 0) begin q = sx / sy; r = sx % sy; l = q[31:0]; h = r[31:0]; end
      MD_DIVU:  if (y != 0) begin q = ux / uy; r = ux % uy; l = q[31:0]; h = r[31:0]; end
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; ctl = op; a = x; b = y;
    p_hi = m_hi; p_lo = m_lo;
    model_op(op, x, y, p_hi, p_lo);
    e.hi  = p_hi;
    e.lo  = p_lo;
    e.lat = (op == MD_MULT || op == MD_MULTU) ? ML : DL;
    op_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; ctl = MD_NONE;
  endtask

  task automatic wait_done();
    bit done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy && op_q.size() == 0) begin done = 1; break; end
    end
    if (!done) begin
      fail("completion_timeout");
      op_q.delete();
    end
    m_hi = p_hi;
    m_lo = p_lo;
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] x);
    @(posedge clk); #1;
    ctl = op; a = x;
    if (op == MD_MTHI) m_hi = x; else m_lo = x;
    p_hi = m_hi; p_lo = m_lo;
    @(posedge clk); #1;
    ctl = MD_NONE;
  endtask

  task automatic read(input logic [3:0] op);
    @(posedge clk); #1;
    ctl = op;
    rd_q.push_back(op == MD_MFHI ? m_hi : m_lo);
    @(posedge clk); #1;
    ctl = MD_NONE;
  endtask

  // Monitor: a busy fall retires one queued operation; an MF op retires one read.
  initial begin
    int   cnt = 0;
    logic pb  = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt = 0;
        pb  = 1'b0;
      end else begin
        if (busy) cnt++;
        else if (pb) begin
          if (op_q.size() == 0) fail("unexpected_completion");
          else begin
            e = op_q.pop_front();
            chk("busy_cycles", 32'(cnt), 32'(e.lat));
            chk("HI", hi, e.hi);
            chk("LO", lo, e.lo);
          end
          cnt = 0;
        end
        pb = busy;
        if (ctl == MD_MFHI || ctl == MD_MFLO) begin
          if (rd_q.size() == 0) fail("unexpected_read");
          else chk("result", result, rd_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;

    reset = 1'b1; start = 1'b0; ctl = MD_NONE; a = 32'd0; b = 32'd0;
    p_hi = 32'd0; p_lo = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_HI", hi, 32'd0);
    chk("reset_LO", lo, 32'd0);
    chk("reset_result", result, 32'd0);
    reset = 1'b0;

    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);       wait_done();
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);      wait_done();
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);        wait_done();
    issue(MD_DIVU, 32'd7, 32'd0);               wait_done();
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();

    move_to(MD_MTLO, 32'h1234_5678);
    read(MD_MFLO);
    move_to(MD_MTHI, 32'hCAFE_F00D);
    read(MD_MFHI);

    // Start and MTHI while a mult is in flight must both be dropped.
    issue(MD_MULT, 32'd1000, 32'hFFFF_FF00);
    start = 1'b1; ctl = MD_DIV; a = 32'd99; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0; ctl = MD_MTHI; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    ctl = MD_NONE;
    wait_done();
    read(MD_MFHI);

    // Non-arith codes with start must not occupy the unit.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      start = 1'b1; ctl = (i == 0) ? MD_NONE : 4'($urandom_range(9, 15));
      @(posedge clk); #1;
      start = 1'b0; ctl = MD_NONE;
      chk("ignored_start_busy", 32'(busy), 32'd0);
    end

    // Reset mid-divide discards the pending result.
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_HI", hi, 32'd0);
    chk("midreset_LO", lo, 32'd0);
    op_q.delete();
    m_hi = 32'd0; m_lo = 32'd0; p_hi = 32'd0; p_lo = 32'd0;
    @(posedge clk); #1 reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("postreset_busy", 32'(busy), 32'd0);
    chk("postreset_HI", hi, 32'd0);
    chk("postreset_LO", lo, 32'd0);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 4));
      x  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       y = 32'd0;
        1:       y = 32'd1;
        2:       y = 32'hFFFF_FFFF;
        default: y = $urandom;
      endcase
      issue(op, x, y);
      read(MD_MFHI);
      wait_done();
      read(MD_MFHI);
      read(MD_MFLO);
      if ($urandom_range(0, 3) == 0) begin
        move_to($urandom_range(0, 1) == 0 ? MD_MTHI : MD_MTLO, $urandom);
        read(MD_MFHI);
        read(MD_MFLO);
      end
    end

    repeat (3) @(posedge clk);
    if (op_q.size() != 0) fail("pending_ops_left");
    if (rd_q.size() != 0) fail("pending_reads_left");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
